// File: rtl/riscv_v_mul_seq.sv
// Sequencer for the 128-bit vector multiply datapath: accepts one op with its
// beat count, streams operand beats through the multiplier and registers each
// result into a single-entry valid/ready output stage.
// Optional: define RISCV_V_MUL_SEQ_PERF_EN to add perf_ops/perf_stall counters.
module riscv_v_mul_seq #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8,
  parameter int unsigned SRC_WIDTH  = DATA_WIDTH + 2 * NUM_BYTES,
  parameter int unsigned MAX_BEATS  = 8,
  parameter int unsigned BEAT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic                  op_is_mul,
  input  logic                  op_is_high,
  input  logic                  op_is_signed,
  input  logic [4:0]            op_osize_vector,
  input  logic [BEAT_CNT_W-1:0] op_num_beats,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [SRC_WIDTH-1:0]  src_a,
  input  logic [SRC_WIDTH-1:0]  src_b,
  output logic                  mul_is_mul,
  output logic                  mul_is_high,
  output logic                  mul_is_signed,
  output logic [4:0]            mul_osize_vector,
  output logic [SRC_WIDTH-1:0]  mul_srca,
  output logic [SRC_WIDTH-1:0]  mul_srcb,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_last,
  output logic                  busy
`ifdef RISCV_V_MUL_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [BEAT_CNT_W-1:0] MAX_B = BEAT_CNT_W'(MAX_BEATS);
  localparam logic [BEAT_CNT_W-1:0] ONE_B = BEAT_CNT_W'(1);

  state_t                  state_q, state_d;
  logic                    cfg_is_mul, cfg_is_high, cfg_is_signed;
  logic [4:0]              cfg_osize;
  logic [BEAT_CNT_W-1:0]   beats_left;
  logic [BEAT_CNT_W-1:0]   num_beats_eff;
  logic                    src_fire;
  logic                    res_fire;

  // Clamp requested beat count into 1..MAX_BEATS
  always_comb begin
    num_beats_eff = op_num_beats;
    if (op_num_beats == '0)
      num_beats_eff = ONE_B;
    else if (op_num_beats > MAX_B)
      num_beats_eff = MAX_B;
  end

  // Next-state and handshake-ready generation
  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    src_ready = 1'b0;
    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_d = RUN;
      end
      RUN: begin
        src_ready = !res_valid || res_ready;
        if (src_valid && src_ready && beats_left == ONE_B) state_d = DRAIN;
      end
      DRAIN: begin
        if (res_valid && res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign src_fire = src_valid && src_ready;
  assign res_fire = res_valid && res_ready;
  assign busy     = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latch op configuration when an op is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_is_mul    <= 1'b0;
      cfg_is_high   <= 1'b0;
      cfg_is_signed <= 1'b0;
      cfg_osize     <= '0;
    end else if (state_q == IDLE && op_valid) begin
      cfg_is_mul    <= op_is_mul;
      cfg_is_high   <= op_is_high;
      cfg_is_signed <= op_is_signed;
      cfg_osize     <= op_osize_vector;
    end
  end

  // Beat counter: loaded on op accept, decremented per operand handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beats_left <= '0;
    else if (state_q == IDLE && op_valid)
      beats_left <= num_beats_eff;
    else if (src_fire)
      beats_left <= beats_left - ONE_B;
  end

  // Output stage: a new beat overrides a same-cycle consume, keeping full rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_data  <= '0;
    end else if (src_fire) begin
      res_valid <= 1'b1;
      res_last  <= (beats_left == ONE_B);
      res_data  <= mul_result;
    end else if (res_fire) begin
      res_valid <= 1'b0;
    end
  end

  // Multiplier drive; is_mul low gates operand A inside the multiplier
  assign mul_srca         = src_a;
  assign mul_srcb         = src_b;
  assign mul_is_mul       = cfg_is_mul && (state_q == RUN) && src_valid;
  assign mul_is_high      = cfg_is_high;
  assign mul_is_signed    = cfg_is_signed;
  assign mul_osize_vector = cfg_osize;

`ifdef RISCV_V_MUL_SEQ_PERF_EN
  // Completed-op and operand-stall counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (state_q == DRAIN && res_fire)
        perf_ops <= perf_ops + 32'd1;
      if (state_q == RUN && src_valid && !src_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_v_mul_seq.sv
// Self-checking bench for riscv_v_mul_seq with a behavioural stand-in multiplier.
module tb_riscv_v_mul_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid, op_ready, op_is_mul, op_is_high, op_is_signed;
  logic [4:0]   op_osize_vector;
  logic [3:0]   op_num_beats;
  logic         src_valid, src_ready;
  logic [159:0] src_a, src_b;
  logic         mul_is_mul, mul_is_high, mul_is_signed;
  logic [4:0]   mul_osize_vector;
  logic [159:0] mul_srca, mul_srcb;
  logic [127:0] mul_result;
  logic         res_valid, res_ready, res_last, busy;
  logic [127:0] res_data;
`ifdef RISCV_V_MUL_SEQ_PERF_EN
  logic [31:0]  perf_ops, perf_stall;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int ops_exp  = 0;
  int stall_exp = 0;

  always #5 clk = ~clk;

  // Stand-in multiplier: per-byte low product, control bits folded into top byte
  function automatic logic [127:0] lane_mul(input logic [159:0] a, input logic [159:0] b,
                                            input logic m, input logic h, input logic s,
                                            input logic [4:0] o);
    logic [127:0] r;
    logic [15:0]  p;
    r = '0;
    if (m) begin
      for (int i = 0; i < 16; i++) begin
        p = {8'h00, a[i*8 +: 8]} * {8'h00, b[i*8 +: 8]};
        r[i*8 +: 8] = p[7:0];
      end
      r[127:120] = r[127:120] ^ {h, s, o, 1'b0};
    end
    return r;
  endfunction

  assign mul_result = lane_mul(mul_srca, mul_srcb, mul_is_mul, mul_is_high, mul_is_signed,
                               mul_osize_vector);

  riscv_v_mul_seq #(.DATA_WIDTH(128), .MAX_BEATS(8), .BEAT_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_mul(op_is_mul), .op_is_high(op_is_high),
    .op_is_signed(op_is_signed), .op_osize_vector(op_osize_vector), .op_num_beats(op_num_beats),
    .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .mul_is_mul(mul_is_mul), .mul_is_high(mul_is_high), .mul_is_signed(mul_is_signed),
    .mul_osize_vector(mul_osize_vector), .mul_srca(mul_srca), .mul_srcb(mul_srcb),
    .mul_result(mul_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy)
`ifdef RISCV_V_MUL_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic reset_checks();
    #1;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_last", res_last, 1'b0);
    check("rst_res_data", res_data, 128'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_src_ready", src_ready, 1'b0);
    ops_exp = 0;
    stall_exp = 0;
  endtask

  // One op: vmode 0=continuous src_valid, 1=random; rmode 0=always ready,
  // 1=random, 2=hold res_ready low 5 cycles at first result; abort_at>0 stops early
  task automatic run_op(input logic [3:0] nb, input logic m, input logic h, input logic s,
                        input logic [4:0] o, input int vmode, input int rmode,
                        input bit fixed, input logic [159:0] fa, input logic [159:0] fb,
                        input int abort_at);
    int eff, sent, got, cyc, hold;
    logic [159:0] aq[$], bq[$];
    logic [127:0] eq[$];
    logic exp_rv, exp_sr;
    eff = (nb == 4'd0) ? 1 : ((nb > 4'd8) ? 8 : int'(nb));
    for (int i = 0; i < eff; i++) begin
      aq.push_back(fixed ? fa : rnd160());
      bq.push_back(fixed ? fb : rnd160());
      eq.push_back(lane_mul(aq[i], bq[i], m, h, s, o));
    end
    #1;
    check("op_ready_before_op", op_ready, 1'b1);
    op_valid = 1'b1; op_is_mul = m; op_is_high = h; op_is_signed = s;
    op_osize_vector = o; op_num_beats = nb;
    @(negedge clk);
    op_valid = 1'b0;
    op_is_mul = 1'($urandom); op_is_high = 1'($urandom); op_is_signed = 1'($urandom);
    op_osize_vector = 5'($urandom); op_num_beats = 4'($urandom);
    sent = 0; got = 0; cyc = 0; hold = 0;
    while (got < eff && cyc < 300 && !(abort_at > 0 && got >= abort_at)) begin
      src_valid = (sent < eff) && (vmode == 0 || $urandom_range(0, 2) != 0);
      src_a = (sent < eff) ? aq[sent] : rnd160();
      src_b = (sent < eff) ? bq[sent] : rnd160();
      if (rmode == 0) res_ready = 1'b1;
      else if (rmode == 1) res_ready = 1'($urandom);
      else if (sent > got && hold < 5) begin res_ready = 1'b0; hold++; end
      else res_ready = 1'b1;
      #1;
      exp_rv = (sent > got);
      exp_sr = (sent < eff) && (sent == got || res_ready);
      check("busy_in_op", busy, 1'b1);
      check("op_ready_in_op", op_ready, 1'b0);
      check("res_valid", res_valid, exp_rv);
      if (exp_rv) begin
        check("res_data", res_data, eq[got]);
        check("res_last", res_last, (got == eff - 1));
      end
      check("src_ready", src_ready, exp_sr);
      check("mul_ctrl", {mul_is_mul, mul_is_high, mul_is_signed, mul_osize_vector},
            {m && src_valid, h, s, o});
      check("mul_srca", mul_srca, src_a);
      check("mul_srcb", mul_srcb, src_b);
      if (src_valid && !exp_sr) stall_exp++;
      if (exp_rv && res_ready) got++;
      if (src_valid && exp_sr) sent++;
      @(negedge clk);
      cyc++;
    end
    if (abort_at == 0) begin
      check("op_done_beats", got, eff);
      if (got == eff) ops_exp++;
      src_valid = 1'b0;
      res_ready = 1'($urandom);
      #1;
      check("idle_busy", busy, 1'b0);
      check("idle_op_ready", op_ready, 1'b1);
      check("idle_res_valid", res_valid, 1'b0);
    end
  endtask

  initial begin
    logic [159:0] a3, b5;
    logic [3:0]   rnb;
    rst_n = 1'b0; op_valid = 1'b0; op_is_mul = 1'b0; op_is_high = 1'b0; op_is_signed = 1'b0;
    op_osize_vector = '0; op_num_beats = '0; src_valid = 1'b0; src_a = '0; src_b = '0;
    res_ready = 1'b0;
    reset_checks();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit unsigned, single beat, 3*5
    a3 = {32'h0, {16{8'h03}}};
    b5 = {32'h0, {16{8'h05}}};
    run_op(4'd1, 1'b1, 1'b0, 1'b0, 5'b00001, 0, 0, 1'b1, a3, b5, 0);
    // 16-bit signed high, 4 beats at full rate
    run_op(4'd4, 1'b1, 1'b1, 1'b1, 5'b00010, 0, 0, 1'b0, '0, '0, 0);
    // Backpressure after first result
    run_op(4'd3, 1'b1, 1'b0, 1'b1, 5'b00100, 0, 2, 1'b0, '0, '0, 0);
    // Beat-count clamping
    run_op(4'd0, 1'b1, 1'b0, 1'b0, 5'b01000, 0, 0, 1'b0, '0, '0, 0);
    run_op(4'd15, 1'b1, 1'b1, 1'b0, 5'b10000, 0, 1, 1'b0, '0, '0, 0);
    // is_mul=0 gives zero results
    run_op(4'd2, 1'b0, 1'b1, 1'b1, 5'b00001, 0, 0, 1'b0, '0, '0, 0);

    // Reset mid-op after two beats consumed
    run_op(4'd4, 1'b1, 1'b0, 1'b0, 5'b00100, 0, 0, 1'b0, '0, '0, 2);
    rst_n = 1'b0;
    src_valid = 1'b0;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(4'd2, 1'b1, 1'b0, 1'b1, 5'b00010, 0, 0, 1'b0, '0, '0, 0);

    // Randomized ops with random valid/ready patterns
    for (int k = 0; k < 12; k++) begin
      rnb = 4'($urandom);
      run_op(rnb, ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
             5'(1 << $urandom_range(0, 4)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'b0, '0, '0, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

`ifdef RISCV_V_MUL_SEQ_PERF_EN
    #1;
    check("perf_ops", perf_ops, 32'(ops_exp));
    check("perf_stall", perf_stall, 32'(stall_exp));
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
